// File: rtl/sum_serializer_if.sv
// Bus bundle between the adder-side producer / pad-side consumer and the
// sum serializer. Signal names keep the block's historical _i/_o suffixes,
// which are seen from the serializer's point of view.
//
// Handshake: a word on sum_i is taken on a rising clk edge where
// sum_valid_i && sum_ready_o. sum_ready_o depends only on registered
// occupancy (and reset), never on sum_valid_i, so a producer may look at it
// before deciding to drive. sum_valid_i while sum_ready_o is low is not
// stalled: the word is dropped and overflow_o latches high.
interface sum_serializer_if #(
  parameter int DATA_W     = 5,
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] sum_i;
  logic              sum_valid_i;
  logic              sum_ready_o;
  logic              ser_en_i;
  logic              ser_data_o;
  logic              ser_frame_o;
  logic [LVL_W-1:0]  fifo_level_o;
  logic              overflow_o;

  // Serializer side.
  modport slave (
    input  sum_i, sum_valid_i, ser_en_i,
    output sum_ready_o, ser_data_o, ser_frame_o, fifo_level_o, overflow_o
  );

  // Producer / pad driver side.
  modport master (
    output sum_i, sum_valid_i, ser_en_i,
    input  sum_ready_o, ser_data_o, ser_frame_o, fifo_level_o, overflow_o
  );
endinterface

// File: rtl/sum_serializer.sv
// Buffers adder sums in a small FIFO and shifts each word out MSB-first on a
// single serial line, with a frame strobe on the first bit of every word.
// Words stream back-to-back when the FIFO holds data and readout is enabled.
module sum_serializer #(
  parameter int DATA_W     = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  sum_serializer_if.slave bus,
  output logic [0:0]     dbg_state
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(DATA_W - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              overflow;

  logic [0:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  logic full;
  logic empty;
  logic ready;
  logic push;
  logic load;

  // Flow control: readiness comes from the registered level only, so a pop
  // on the same edge cannot reopen a full FIFO within that cycle.
  always_comb begin
    full  = (level == FULL_LVL);
    empty = (level == '0);
    ready = !rst && !full;
    push  = bus.sum_valid_i && ready;
    load  = !empty && bus.ser_en_i &&
            ((state == ST_IDLE) || ((state == ST_SHIFT) && (cnt == '0)));
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.sum_i;
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      if (push && !load)      level <= level + 1'b1;
      else if (load && !push) level <= level - 1'b1;
      if (bus.sum_valid_i && !ready) overflow <= 1'b1;
    end
  end

  // Serializer FSM: load from the FIFO head, shift MSB-first, reload with no
  // gap on the last bit when more data is waiting and readout is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            shreg <= mem[rd_ptr];
            cnt   <= CNT_TOP;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt == '0) begin
            if (load) begin
              shreg <= mem[rd_ptr];
              cnt   <= CNT_TOP;
            end else begin
              shreg <= '0;
              state <= ST_IDLE;
            end
          end else begin
            shreg <= shreg << 1;
            cnt   <= cnt - 1'b1;
          end
        end
        default: begin
          shreg <= '0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The shift register is cleared whenever the FSM idles, so its MSB can
  // drive the line directly and reads 0 outside a word.
  assign bus.ser_data_o   = shreg[DATA_W-1];
  assign bus.ser_frame_o  = (state == ST_SHIFT) && (cnt == CNT_TOP);
  assign bus.sum_ready_o  = ready;
  assign bus.fifo_level_o = level;
  assign bus.overflow_o   = overflow;
  assign dbg_state        = state;
endmodule

// File: tb/tb_sum_serializer.sv
// Directed bench for sum_serializer: reset, single word, back-to-back words,
// fill/overflow, enable drop mid-word, reset mid-word and pointer wrap.
module tb_sum_serializer;
  logic       clk;
  logic       rst;
  logic [0:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  sum_serializer_if #(.DATA_W(5), .FIFO_DEPTH(8)) bus ();

  sum_serializer #(.DATA_W(5), .FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sum_i = '0; bus.sum_valid_i = 1'b0; bus.ser_en_i = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.sum_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", bus.sum_ready_o); end
    n_cmp++; if (bus.fifo_level_o !== 4'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level_o); end
    n_cmp++; if (bus.ser_data_o !== 1'b0) begin n_err++; $display("FAIL reset_data got=%b exp=0", bus.ser_data_o); end
    n_cmp++; if (bus.ser_frame_o !== 1'b0) begin n_err++; $display("FAIL reset_frame got=%b exp=0", bus.ser_frame_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow_o); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.sum_ready_o !== 1'b1) begin n_err++; $display("FAIL release_ready got=%b exp=1", bus.sum_ready_o); end
  endtask

  task automatic test_single();
    logic [4:0] w;
    w = 5'b10110;
    bus.ser_en_i = 1'b1;
    bus.sum_i = w; bus.sum_valid_i = 1'b1;
    tick();
    bus.sum_valid_i = 1'b0;
    n_cmp++; if (bus.fifo_level_o !== 4'd1) begin n_err++; $display("FAIL single_level_after_push got=%0d exp=1", bus.fifo_level_o); end
    n_cmp++; if (bus.ser_data_o !== 1'b0 || bus.ser_frame_o !== 1'b0) begin n_err++; $display("FAIL single_pre_load got=%b%b exp=00", bus.ser_data_o, bus.ser_frame_o); end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.ser_data_o !== w[4-i]) begin n_err++; $display("FAIL single_bit%0d got=%b exp=%b", i, bus.ser_data_o, w[4-i]); end
      n_cmp++; if (bus.ser_frame_o !== (i == 0)) begin n_err++; $display("FAIL single_frame%0d got=%b exp=%b", i, bus.ser_frame_o, (i == 0)); end
      tick();
    end
    n_cmp++; if (bus.ser_data_o !== 1'b0 || bus.ser_frame_o !== 1'b0) begin n_err++; $display("FAIL single_after got=%b%b exp=00", bus.ser_data_o, bus.ser_frame_o); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL single_idle got=%b exp=0", dbg_state); end
    n_cmp++; if (bus.fifo_level_o !== 4'd0) begin n_err++; $display("FAIL single_level_end got=%0d exp=0", bus.fifo_level_o); end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp_bits;
    exp_bits = 15'b11110_00000_10101;
    bus.ser_en_i = 1'b1;
    bus.sum_i = 5'd30; bus.sum_valid_i = 1'b1;
    tick();
    bus.sum_i = 5'd0;
    tick();
    for (int i = 0; i < 15; i++) begin
      if (i == 0) begin bus.sum_i = 5'd21; bus.sum_valid_i = 1'b1; end
      else bus.sum_valid_i = 1'b0;
      n_cmp++; if (bus.ser_data_o !== exp_bits[14-i]) begin n_err++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, bus.ser_data_o, exp_bits[14-i]); end
      n_cmp++; if (bus.ser_frame_o !== (i % 5 == 0)) begin n_err++; $display("FAIL b2b_frame%0d got=%b exp=%b", i, bus.ser_frame_o, (i % 5 == 0)); end
      tick();
    end
    n_cmp++; if (dbg_state !== 1'b0 || bus.ser_data_o !== 1'b0) begin n_err++; $display("FAIL b2b_idle got state=%b data=%b exp 0 0", dbg_state, bus.ser_data_o); end
    n_cmp++; if (bus.fifo_level_o !== 4'd0) begin n_err++; $display("FAIL b2b_level got=%0d exp=0", bus.fifo_level_o); end
  endtask

  task automatic test_fill_overflow();
    logic [4:0] w;
    bus.ser_en_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.sum_i = 5'(i + 1); bus.sum_valid_i = 1'b1;
      tick();
    end
    n_cmp++; if (bus.fifo_level_o !== 4'd8) begin n_err++; $display("FAIL fill_level got=%0d exp=8", bus.fifo_level_o); end
    n_cmp++; if (bus.sum_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_ready got=%b exp=0", bus.sum_ready_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL fill_no_overflow_yet got=%b exp=0", bus.overflow_o); end
    bus.sum_i = 5'd31;
    tick();
    bus.sum_valid_i = 1'b0;
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL overflow_set got=%b exp=1", bus.overflow_o); end
    n_cmp++; if (bus.fifo_level_o !== 4'd8) begin n_err++; $display("FAIL overflow_level got=%0d exp=8", bus.fifo_level_o); end
    bus.ser_en_i = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      w = 5'(i / 5 + 1);
      n_cmp++; if (bus.ser_data_o !== w[4 - (i % 5)]) begin n_err++; $display("FAIL drain_bit%0d got=%b exp=%b", i, bus.ser_data_o, w[4 - (i % 5)]); end
      if (i % 5 == 0) begin
        n_cmp++; if (bus.ser_frame_o !== 1'b1) begin n_err++; $display("FAIL drain_frame%0d got=%b exp=1", i, bus.ser_frame_o); end
        n_cmp++; if (bus.fifo_level_o !== 4'(7 - i / 5)) begin n_err++; $display("FAIL drain_level%0d got=%0d exp=%0d", i, bus.fifo_level_o, 7 - i / 5); end
      end
      tick();
    end
    n_cmp++; if (dbg_state !== 1'b0 || bus.fifo_level_o !== 4'd0) begin n_err++; $display("FAIL drain_end got state=%b level=%0d exp 0 0", dbg_state, bus.fifo_level_o); end
    n_cmp++; if (bus.overflow_o !== 1'b1) begin n_err++; $display("FAIL overflow_sticky got=%b exp=1", bus.overflow_o); end
  endtask

  task automatic test_enable_drop();
    logic [4:0] a;
    logic [4:0] b;
    a = 5'b11001; b = 5'b01011;
    bus.ser_en_i = 1'b0;
    bus.sum_i = a; bus.sum_valid_i = 1'b1; tick();
    bus.sum_i = b; tick();
    bus.sum_valid_i = 1'b0;
    bus.ser_en_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.ser_en_i = 1'b0;
      n_cmp++; if (bus.ser_data_o !== a[4-i]) begin n_err++; $display("FAIL drop_a_bit%0d got=%b exp=%b", i, bus.ser_data_o, a[4-i]); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (dbg_state !== 1'b0 || bus.ser_frame_o !== 1'b0 || bus.ser_data_o !== 1'b0) begin n_err++; $display("FAIL drop_hold%0d got state=%b frame=%b data=%b exp 0 0 0", i, dbg_state, bus.ser_frame_o, bus.ser_data_o); end
      n_cmp++; if (bus.fifo_level_o !== 4'd1) begin n_err++; $display("FAIL drop_level%0d got=%0d exp=1", i, bus.fifo_level_o); end
      tick();
    end
    bus.ser_en_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.ser_data_o !== b[4-i]) begin n_err++; $display("FAIL drop_b_bit%0d got=%b exp=%b", i, bus.ser_data_o, b[4-i]); end
      n_cmp++; if (bus.ser_frame_o !== (i == 0)) begin n_err++; $display("FAIL drop_b_frame%0d got=%b exp=%b", i, bus.ser_frame_o, (i == 0)); end
      tick();
    end
    n_cmp++; if (dbg_state !== 1'b0 || bus.fifo_level_o !== 4'd0) begin n_err++; $display("FAIL drop_end got state=%b level=%0d exp 0 0", dbg_state, bus.fifo_level_o); end
  endtask

  task automatic test_reset_mid();
    bus.ser_en_i = 1'b0;
    bus.sum_valid_i = 1'b1;
    bus.sum_i = 5'd31; tick();
    bus.sum_i = 5'd17; tick();
    bus.sum_i = 5'd10; tick();
    bus.sum_valid_i = 1'b0;
    bus.ser_en_i = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++; if (bus.ser_data_o !== 1'b1) begin n_err++; $display("FAIL rstmid_bit2 got=%b exp=1", bus.ser_data_o); end
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.ser_data_o !== 1'b0 || bus.ser_frame_o !== 1'b0) begin n_err++; $display("FAIL rstmid_line got=%b%b exp=00", bus.ser_data_o, bus.ser_frame_o); end
    n_cmp++; if (bus.fifo_level_o !== 4'd0) begin n_err++; $display("FAIL rstmid_level got=%0d exp=0", bus.fifo_level_o); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow got=%b exp=0", bus.overflow_o); end
    n_cmp++; if (bus.sum_ready_o !== 1'b0) begin n_err++; $display("FAIL rstmid_ready got=%b exp=0", bus.sum_ready_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.sum_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_release_ready got=%b exp=1", bus.sum_ready_o); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if (bus.ser_data_o !== 1'b0 || bus.ser_frame_o !== 1'b0 || bus.fifo_level_o !== 4'd0) begin n_err++; $display("FAIL rstmid_stale%0d got data=%b frame=%b level=%0d exp 0 0 0", i, bus.ser_data_o, bus.ser_frame_o, bus.fifo_level_o); end
    end
  endtask

  task automatic test_wrap();
    logic [4:0] exp_q[$];
    logic [4:0] cur;
    logic [4:0] exp_w;
    int nbits;
    int pushed;
    int rcvd;
    int cyc;
    nbits = 0; pushed = 0; rcvd = 0; cyc = 0; cur = '0;
    bus.ser_en_i = 1'b1;
    while (!(pushed == 20 && rcvd == 20) && cyc < 400) begin
      // Collect serial bits into words and score them against the queue.
      if (bus.ser_frame_o) begin
        if (nbits != 0) begin
          n_cmp++; n_err++; $display("FAIL wrap_short_word got=%0d bits exp=5", nbits);
        end
        cur = {4'b0, bus.ser_data_o};
        nbits = 1;
      end else if (nbits > 0) begin
        cur = {cur[3:0], bus.ser_data_o};
        nbits++;
      end
      if (nbits == 5) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 5'bx;
        n_cmp++; if (cur !== exp_w) begin n_err++; $display("FAIL wrap_word%0d got=%0d exp=%0d", rcvd, cur, exp_w); end
        rcvd++;
        nbits = 0;
      end
      if (pushed < 20 && bus.sum_ready_o) begin
        bus.sum_i = 5'((pushed * 7 + 3) % 32);
        bus.sum_valid_i = 1'b1;
        exp_q.push_back(5'((pushed * 7 + 3) % 32));
        pushed++;
      end else begin
        bus.sum_valid_i = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.sum_valid_i = 1'b0;
    n_cmp++; if (rcvd !== 20) begin n_err++; $display("FAIL wrap_timeout got=%0d words exp=20", rcvd); end
    n_cmp++; if (bus.overflow_o !== 1'b0) begin n_err++; $display("FAIL wrap_overflow got=%b exp=0", bus.overflow_o); end
    tick();
    n_cmp++; if (bus.fifo_level_o !== 4'd0 || dbg_state !== 1'b0) begin n_err++; $display("FAIL wrap_end got level=%0d state=%b exp 0 0", bus.fifo_level_o, dbg_state); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sum_serializer.md
Name: sum_serializer

Overview:
- Downstream consumer of the 4-bit adder's 5-bit sum in the APP top level.
- Captures each sum presented with a valid strobe into a small FIFO.
- Shifts each buffered word off-chip MSB-first on a single serial line, with a frame strobe marking the first bit of each word.
- Decouples sum production from the serial readout so the core never stalls on the pad interface.

Parameters:
- DATA_W, 5, width of the sum word and bits per serial frame.
- FIFO_DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  core clock, sampled on rising edge.
- rst  input  1  reset, synchronous, active-high.
- sum_i  input  DATA_W  sum word from the adder.
- sum_valid_i  input  1  sum_i valid this cycle.
- sum_ready_o  output  1  FIFO can accept a word this cycle.
- ser_en_i  input  1  readout enable; gates the start of a new word only.
- ser_data_o  output  1  serial data, MSB first.
- ser_frame_o  output  1  high during the first (MSB) bit of each word.
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_o  output  1  sticky flag: a word was dropped because the FIFO was full.

Behaviour:
- Reset (rst high at a clk edge):
  - FIFO pointers and level cleared to 0; overflow_o cleared to 0.
  - FSM goes to IDLE; shift register and bit counter cleared.
  - ser_data_o and ser_frame_o are 0.
  - sum_ready_o is 0 while rst is high, and 1 in the first cycle after release.
  - Reset mid-word aborts the word immediately; no partial bits follow.
- Write side:
  - sum_ready_o = !full, with full derived from the registered level.
  - Word accepted on an edge with sum_valid_i && sum_ready_o; the level increments unless a pop occurs on the same edge.
  - When full, a pop on the same edge does NOT raise sum_ready_o that cycle.
  - sum_valid_i while sum_ready_o=0: the word is dropped and overflow_o is set on that edge.
  - overflow_o stays set until rst.
- Simultaneous push and pop: level unchanged; data ordering preserved (FIFO, first in first out).
- FSM, two states:
  - IDLE: ser_data_o=0, ser_frame_o=0. If FIFO not empty && ser_en_i, then on the edge: load the shift register with the FIFO head, pop, set bit counter to DATA_W-1, go to SHIFT.
  - SHIFT: ser_data_o = shift register MSB (driven directly from the register). ser_frame_o=1 only when bit counter == DATA_W-1.
    - Each edge shifts left by 1 and decrements the counter.
    - On the edge where the counter is 0: if FIFO not empty && ser_en_i, load the next word and pop (back-to-back, zero gap cycles); otherwise go to IDLE.
  - ser_en_i deasserted during SHIFT: the current word completes; no new word starts.
- Latency:
  - Word accepted at edge N, FIFO empty, FSM IDLE, ser_en_i=1: the load occurs at edge N+1.
  - Its MSB appears on ser_data_o with ser_frame_o=1 in the cycle after edge N+1.
  - Each word occupies exactly DATA_W consecutive cycles.
- Widths: data is stored and shifted unmodified; no arithmetic on the payload. fifo_level_o ranges 0..FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH; full is level==FIFO_DEPTH and empty is level==0.

Test Plan:
- Single word: after reset with ser_en_i=1, push sum_i=5'b10110 once -> two edges later ser_data_o = 1,0,1,1,0 over 5 cycles, ser_frame_o=1 on the first bit only, then ser_data_o=0 and FSM idle.
- Back-to-back: push 30, 0, 21 on consecutive cycles with ser_en_i=1 -> 15 contiguous bits 11110 00000 10101; ser_frame_o high at bits 0, 5 and 10; no gap cycles.
- Fill/overflow: ser_en_i=0, push 9 words -> first 8 accepted, fifo_level_o=8, sum_ready_o=0; 9th dropped and overflow_o=1. Then raise ser_en_i -> the 8 words stream out in order, level counts down to 0, overflow_o stays 1.
- Enable drop mid-word: two words queued, deassert ser_en_i at the 2nd bit of word 1 -> word 1 completes all 5 bits; word 2 is held (level=1) until ser_en_i returns, then starts with ser_frame_o=1.
- Reset mid-operation: assert rst at the 3rd bit of a word with 3 words queued -> next cycle ser_data_o=0, ser_frame_o=0, fifo_level_o=0, overflow_o=0, sum_ready_o=0 during rst and 1 after release; no stale bits appear afterwards.
- Wrap-around: push and drain 20 words continuously with ser_en_i=1 (pointers wrap twice) -> output sequence matches input order exactly and overflow_o remains 0.
